// File: rtl/ntt_core_gf64_out_reduce_if.sv
// Stream bus for the GF(p) output reducer, p = 2^64-2^32+1: partially reduced
// input beats, canonical output beats and the sticky protocol error flags.
interface ntt_core_gf64_out_reduce_if #(
   parameter int PSI       = 4,
   parameter int R         = 2,
   parameter int MOD_NTT_W = 64,
   parameter int BPBS_ID_W = 5
);
   logic [PSI*R*(MOD_NTT_W+2)-1:0] in_data;
   logic [PSI*R-1:0]               in_avail;
   logic                           in_sob;
   logic                           in_eob;
   logic                           in_sol;
   logic                           in_eol;
   logic                           in_sos;
   logic                           in_eos;
   logic [BPBS_ID_W-1:0]           in_pbs_id;

   logic [PSI*R*MOD_NTT_W-1:0]     out_data;
   logic [PSI*R-1:0]               out_avail;
   logic                           out_sob;
   logic                           out_eob;
   logic                           out_sol;
   logic                           out_eol;
   logic                           out_sos;
   logic                           out_eos;
   logic [BPBS_ID_W-1:0]           out_pbs_id;
   logic [1:0]                     error;

   modport master (
      output in_data, in_avail, in_sob, in_eob, in_sol, in_eol, in_sos, in_eos, in_pbs_id,
      input  out_data, out_avail, out_sob, out_eob, out_sol, out_eol, out_sos, out_eos,
      input  out_pbs_id, error
   );

   modport slave (
      input  in_data, in_avail, in_sob, in_eob, in_sol, in_eol, in_sos, in_eos, in_pbs_id,
      output out_data, out_avail, out_sob, out_eob, out_sol, out_eol, out_sos, out_eos,
      output out_pbs_id, error
   );
endinterface

// File: rtl/ntt_core_gf64_out_reduce.sv
// Three-stage reducer of signed 66-bit NTT lanes to canonical [0,p), p = 2^64-2^32+1.
// Define NTT_CORE_GF64_OUT_REDUCE_CHECK_EN to build the batch tracker and error flags.
module ntt_core_gf64_out_reduce #(
   parameter int PSI       = 4,
   parameter int R         = 2,
   parameter int MOD_NTT_W = 64,
   parameter int BPBS_ID_W = 5
) (
   input  logic                      clk,
   input  logic                      s_rst,
   ntt_core_gf64_out_reduce_if.slave bus
);
   localparam int LANES = PSI * R;
   localparam int XW    = MOD_NTT_W + 2;
   localparam int MK_W  = 6;

   localparam logic [MOD_NTT_W-1:0] P_MOD   = MOD_NTT_W'(64'hFFFF_FFFF_0000_0001);
   localparam logic [XW-1:0]        P_X     = XW'(P_MOD);
   localparam logic [XW-1:0]        EPS_X   = XW'(64'h0000_0000_FFFF_FFFF);
   localparam logic [XW-1:0]        FOLD_M1 = ~EPS_X + 1'b1;
   localparam logic [XW-1:0]        FOLD_M2 = ~(EPS_X << 1) + 1'b1;

   // Side-band pipeline: markers and id are only meaningful on lane [0][0] beats.
   logic [LANES-1:0]     av1_q, av2_q, av3_q;
   logic [MK_W-1:0]      mk1_d, mk1_q, mk2_q, mk3_q;
   logic [BPBS_ID_W-1:0] id1_d, id1_q, id2_q, id3_q;

   always_comb begin
      mk1_d = '0;
      id1_d = '0;
      if (bus.in_avail[0]) begin
         mk1_d = {bus.in_sob, bus.in_eob, bus.in_sol, bus.in_eol, bus.in_sos, bus.in_eos};
         id1_d = bus.in_pbs_id;
      end
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         av1_q <= '0;
         av2_q <= '0;
         av3_q <= '0;
         mk1_q <= '0;
         mk2_q <= '0;
         mk3_q <= '0;
         id1_q <= '0;
         id2_q <= '0;
         id3_q <= '0;
      end else begin
         av1_q <= bus.in_avail;
         av2_q <= av1_q;
         av3_q <= av2_q;
         mk1_q <= mk1_d;
         mk2_q <= mk1_q;
         mk3_q <= mk2_q;
         id1_q <= id1_d;
         id2_q <= id1_q;
         id3_q <= id2_q;
      end
   end

   assign bus.out_avail  = av3_q;
   assign bus.out_pbs_id = id3_q;
   assign {bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol, bus.out_sos, bus.out_eos} = mk3_q;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [XW-1:0]        x;
         logic [XW-1:0]        fold;
         logic [XW-1:0]        y_d, y_q;
         logic [MOD_NTT_W-1:0] y_plus_p, y_minus_p;
         logic [MOD_NTT_W-1:0] red_d, red_q;
         logic [MOD_NTT_W-1:0] out_d, out_q;

         assign x = bus.in_data[gi*XW +: XW];

         // The two top bits are a signed multiple of 2^64, and 2^64 == 2^32-1 (mod p).
         always_comb begin
            case (x[XW-1 -: 2])
               2'b01:   fold = EPS_X;
               2'b10:   fold = FOLD_M2;
               2'b11:   fold = FOLD_M1;
               default: fold = '0;
            endcase
         end

         // y lies in [-2*(2^32-1), 2p), so one conditional add or subtract of p suffices.
         assign y_d       = {2'b00, x[MOD_NTT_W-1:0]} + fold;
         assign y_plus_p  = y_q[MOD_NTT_W-1:0] + P_MOD;
         assign y_minus_p = y_q[MOD_NTT_W-1:0] - P_MOD;

         always_comb begin
            if (y_q[XW-1]) begin
               red_d = y_plus_p;
            end else if (y_q >= P_X) begin
               red_d = y_minus_p;
            end else begin
               red_d = y_q[MOD_NTT_W-1:0];
            end
         end

         assign out_d = av2_q[gi] ? red_q : '0;

         always_ff @(posedge clk) begin
            if (s_rst) begin
               y_q   <= '0;
               red_q <= '0;
               out_q <= '0;
            end else begin
               y_q   <= y_d;
               red_q <= red_d;
               out_q <= out_d;
            end
         end

         assign bus.out_data[gi*MOD_NTT_W +: MOD_NTT_W] = out_q;
      end
   endgenerate

`ifdef NTT_CORE_GF64_OUT_REDUCE_CHECK_EN
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_IN_BATCH = 1'b1;

   logic [0:0] state_d, state_q;
   logic [1:0] error_d, error_q;

   // Tracker observes the input side only; it never feeds back into the data path.
   always_comb begin
      state_d = state_q;
      error_d = error_q;
      if (bus.in_avail[0]) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_eob && !bus.in_sob) begin
                  error_d[0] = 1'b1;
               end
               if (bus.in_sob && !bus.in_eob) begin
                  state_d = ST_IN_BATCH;
               end
            end
            default: begin
               if (bus.in_sob) begin
                  error_d[0] = 1'b1;
               end
               if (bus.in_eob) begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
      if (bus.in_avail != '0 && bus.in_avail != '1) begin
         error_d[1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         state_q <= ST_IDLE;
         error_q <= '0;
      end else begin
         state_q <= state_d;
         error_q <= error_d;
      end
   end

   assign bus.error = error_q;
`else
   assign bus.error = 2'b00;
`endif

endmodule

// File: tb/tb_ntt_core_gf64_out_reduce.sv
// Randomized self-checking bench for ntt_core_gf64_out_reduce against a
// modular-arithmetic reference model and per-cycle input history.
module tb_ntt_core_gf64_out_reduce;
   localparam int PSI   = 4;
   localparam int R     = 2;
   localparam int W     = 64;
   localparam int IDW   = 5;
   localparam int LANES = PSI * R;
   localparam int XW    = W + 2;
   localparam int NREC  = 2048;
   localparam logic [63:0] P64 = 64'hFFFF_FFFF_0000_0001;
`ifdef NTT_CORE_GF64_OUT_REDUCE_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic s_rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Input history: outputs at cycle c are derived from the inputs of cycle c-3.
   logic [LANES*XW-1:0] in_rec  [NREC];
   logic [LANES-1:0]    av_rec  [NREC];
   logic [5:0]          mk_rec  [NREC];
   logic [IDW-1:0]      id_rec  [NREC];
   logic                rst_rec [NREC];
   logic [1:0]          err_rec [NREC];
   logic [1:0]          m_err;
   logic                m_inb;

   always #5 clk = ~clk;

   ntt_core_gf64_out_reduce_if #(.PSI(PSI), .R(R), .MOD_NTT_W(W), .BPBS_ID_W(IDW)) bus ();

   ntt_core_gf64_out_reduce #(.PSI(PSI), .R(R), .MOD_NTT_W(W), .BPBS_ID_W(IDW)) dut (
      .clk   (clk),
      .s_rst (s_rst),
      .bus   (bus)
   );

   function automatic logic [W-1:0] modp(input logic [XW-1:0] x);
      logic signed [XW+63:0] xs, pm, r;
      pm = {{XW{1'b0}}, P64};
      xs = {{64{x[XW-1]}}, x};
      r  = xs % pm;
      if (r < 0) r = r + pm;
      return r[W-1:0];
   endfunction

   function automatic bit exp_ok(input int c);
      if (c < 3) return 1'b0;
      return !rst_rec[c-1] && !rst_rec[c-2] && !rst_rec[c-3];
   endfunction

   function automatic logic [LANES-1:0] exp_avail(input int c);
      return exp_ok(c) ? av_rec[c-3] : '0;
   endfunction

   function automatic logic [LANES*W-1:0] exp_data(input int c);
      logic [LANES*W-1:0] v;
      v = '0;
      if (exp_ok(c))
         for (int l = 0; l < LANES; l++)
            if (av_rec[c-3][l]) v[l*W +: W] = modp(in_rec[c-3][l*XW +: XW]);
      return v;
   endfunction

   function automatic logic [6+IDW-1:0] exp_side(input int c);
      if (exp_ok(c) && av_rec[c-3][0]) return {mk_rec[c-3], id_rec[c-3]};
      return '0;
   endfunction

   function automatic logic [6+IDW-1:0] obs_side();
      return {bus.out_sob, bus.out_eob, bus.out_sol, bus.out_eol, bus.out_sos, bus.out_eos,
              bus.out_pbs_id};
   endfunction

   function automatic logic [XW-1:0] rand_x();
      logic [XW-1:0] v;
      v[W-1:0]    = {$urandom, $urandom};
      v[XW-1:W]   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
         0: v = {2'b00, P64} + XW'($urandom_range(0, 2)) - XW'(1);
         1: v = -{2'b00, P64} + XW'($urandom_range(0, 2)) - XW'(1);
         2: v[W-1:0] = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [LANES*XW-1:0] rand_beat();
      logic [LANES*XW-1:0] v;
      for (int l = 0; l < LANES; l++) v[l*XW +: XW] = rand_x();
      return v;
   endfunction

   // Drives one cycle of inputs at the falling edge and updates the reference model.
   task automatic apply(input logic rst, input logic [LANES*XW-1:0] d,
                        input logic [LANES-1:0] av, input logic [5:0] mk,
                        input logic [IDW-1:0] id);
      @(negedge clk);
      cyc++;
      s_rst         = rst;
      bus.in_data   = d;
      bus.in_avail  = av;
      {bus.in_sob, bus.in_eob, bus.in_sol, bus.in_eol, bus.in_sos, bus.in_eos} = mk;
      bus.in_pbs_id = id;
      in_rec[cyc]  = d;
      av_rec[cyc]  = av;
      mk_rec[cyc]  = mk;
      id_rec[cyc]  = id;
      rst_rec[cyc] = rst;
      if (rst) begin
         m_err = 2'b00;
         m_inb = 1'b0;
      end else begin
         if (av != '0 && av != '1) m_err[1] = 1'b1;
         if (av[0]) begin
            if ((mk[5] && m_inb) || (mk[4] && !mk[5] && !m_inb)) m_err[0] = 1'b1;
            if (mk[4]) m_inb = 1'b0;
            else if (mk[5]) m_inb = 1'b1;
         end
      end
      err_rec[cyc+1] = CHECK_EN ? m_err : 2'b00;
   endtask

   task automatic idle();
      apply(1'b0, '0, '0, '0, '0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) apply(1'b1, rand_beat(), '1, 6'b111111, '1);
      for (int i = 0; i < 3; i++) begin
         idle();
         checks++;
         if (bus.out_avail !== '0)
            begin failures++; $display("FAIL reset_avail cyc=%0d got=%h want=0", cyc, bus.out_avail); end
         checks++;
         if (bus.out_data !== '0)
            begin failures++; $display("FAIL reset_data cyc=%0d got=%h want=0", cyc, bus.out_data); end
         checks++;
         if (obs_side() !== '0)
            begin failures++; $display("FAIL reset_side cyc=%0d got=%h want=0", cyc, obs_side()); end
         checks++;
         if (bus.error !== 2'b00)
            begin failures++; $display("FAIL reset_error cyc=%0d got=%b want=00", cyc, bus.error); end
      end
   endtask

   task automatic test_corners();
      logic [XW-1:0]       xv [5];
      logic [W-1:0]        ev [5];
      logic [LANES*XW-1:0] d;
      xv = '{66'h3_FFFF_FFFF_FFFF_FFFF, 66'h0_FFFF_FFFF_0000_0001, 66'h1_0000_0000_0000_0000,
             66'h2_0000_0000_0000_0000, 66'h1_FFFF_FFFF_FFFF_FFFF};
      ev = '{64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0000_0000_FFFF_FFFF,
             64'hFFFF_FFFD_0000_0003, 64'h0000_0001_FFFF_FFFD};
      for (int k = 0; k < 9; k++) begin
         if (k < 5) begin
            d = rand_beat();
            d[XW-1:0] = xv[k];
            apply(1'b0, d, '1, {k == 0, k == 4, 4'b0000}, 5'(k));
         end else begin
            idle();
         end
         if (k == 2) begin
            checks++;
            if (bus.out_avail !== '0)
               begin failures++; $display("FAIL corner_early cyc=%0d got=%h want=0", cyc, bus.out_avail); end
         end
         if (k >= 3 && k < 8) begin
            checks++;
            if (bus.out_avail[0] !== 1'b1 || bus.out_data[W-1:0] !== ev[k-3])
               begin failures++; $display("FAIL corner_lane0 k=%0d got=%h want=%h", k-3, bus.out_data[W-1:0], ev[k-3]); end
            checks++;
            if (bus.out_data !== exp_data(cyc))
               begin failures++; $display("FAIL corner_data cyc=%0d got=%h want=%h", cyc, bus.out_data, exp_data(cyc)); end
            checks++;
            if (obs_side() !== exp_side(cyc))
               begin failures++; $display("FAIL corner_side cyc=%0d got=%h want=%h", cyc, obs_side(), exp_side(cyc)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int         remain;
      int         outs;
      logic       sob, eob;
      remain = 0;
      outs   = 0;
      for (int i = 0; i < 3; i++) idle();
      for (int i = 0; i < 1003; i++) begin
         if (i < 1000) begin
            sob = (remain == 0);
            if (sob) remain = $urandom_range(1, 8);
            if (i + remain > 1000) remain = 1000 - i;
            eob = (remain == 1);
            remain--;
            apply(1'b0, rand_beat(), '1, {sob, eob, 4'($urandom)}, 5'($urandom));
         end else begin
            idle();
         end
         if (bus.out_avail[0] === 1'b1) outs++;
         checks++;
         if (bus.out_avail !== exp_avail(cyc))
            begin failures++; $display("FAIL b2b_avail cyc=%0d got=%h want=%h", cyc, bus.out_avail, exp_avail(cyc)); end
         checks++;
         if (bus.out_data !== exp_data(cyc))
            begin failures++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", cyc, bus.out_data, exp_data(cyc)); end
         checks++;
         if (obs_side() !== exp_side(cyc))
            begin failures++; $display("FAIL b2b_side cyc=%0d got=%h want=%h", cyc, obs_side(), exp_side(cyc)); end
         checks++;
         if (bus.error !== err_rec[cyc] || bus.error !== 2'b00)
            begin failures++; $display("FAIL b2b_error cyc=%0d got=%b want=%b", cyc, bus.error, err_rec[cyc]); end
      end
      checks++;
      if (outs != 1000)
         begin failures++; $display("FAIL b2b_count got=%0d want=1000", outs); end
   endtask

   task automatic test_sob_error();
      apply(1'b0, rand_beat(), '1, 6'b100000, 5'd1);
      apply(1'b0, rand_beat(), '1, 6'b100000, 5'd2);
      checks++;
      if (bus.error !== 2'b00)
         begin failures++; $display("FAIL sob_before cyc=%0d got=%b want=00", cyc, bus.error); end
      for (int k = 0; k < 6; k++) begin
         idle();
         checks++;
         if (bus.error !== (CHECK_EN ? 2'b01 : 2'b00))
            begin failures++; $display("FAIL sob_sticky cyc=%0d got=%b want=%b", cyc, bus.error, CHECK_EN ? 2'b01 : 2'b00); end
      end
      apply(1'b1, '0, '0, '0, '0);
      idle();
      checks++;
      if (bus.error !== 2'b00)
         begin failures++; $display("FAIL sob_cleared cyc=%0d got=%b want=00", cyc, bus.error); end
   endtask

   task automatic test_partial_avail();
      logic [LANES*XW-1:0] d;
      apply(1'b1, '0, '0, '0, '0);
      idle();
      d = rand_beat();
      apply(1'b0, d, 8'b0000_0001, 6'b000000, 5'd7);
      checks++;
      if (bus.error !== 2'b00)
         begin failures++; $display("FAIL partial_before cyc=%0d got=%b want=00", cyc, bus.error); end
      for (int k = 1; k <= 4; k++) begin
         idle();
         checks++;
         if (bus.error !== (CHECK_EN ? 2'b10 : 2'b00))
            begin failures++; $display("FAIL partial_error cyc=%0d got=%b want=%b", cyc, bus.error, CHECK_EN ? 2'b10 : 2'b00); end
         if (k == 3) begin
            checks++;
            if (bus.out_avail !== 8'h01 || bus.out_pbs_id !== 5'd7)
               begin failures++; $display("FAIL partial_avail got=%h/%0d want=01/7", bus.out_avail, bus.out_pbs_id); end
            checks++;
            if (bus.out_data[LANES*W-1:W] !== '0 || bus.out_data[W-1:0] !== modp(d[XW-1:0]))
               begin failures++; $display("FAIL partial_data got=%h want lane0=%h rest 0", bus.out_data, modp(d[XW-1:0])); end
         end
      end
   endtask

   task automatic test_reset_mid_batch();
      apply(1'b1, '0, '0, '0, '0);
      idle();
      apply(1'b0, rand_beat(), '1, 6'b100000, 5'd3);
      apply(1'b0, rand_beat(), '1, 6'b000000, 5'd3);
      apply(1'b0, rand_beat(), '1, 6'b000000, 5'd3);
      apply(1'b1, rand_beat(), '1, 6'b000000, 5'd3);
      for (int k = 1; k <= 6; k++) begin
         if (k == 1)      apply(1'b0, rand_beat(), '1, 6'b100000, 5'd9);
         else if (k < 4)  apply(1'b0, rand_beat(), '1, 6'b000000, 5'd9);
         else if (k == 4) apply(1'b0, rand_beat(), '1, 6'b010000, 5'd9);
         else             idle();
         if (k <= 3) begin
            checks++;
            if (bus.out_avail !== '0 || bus.out_data !== '0)
               begin failures++; $display("FAIL rstmid_flush k=%0d got=%h want=0", k, bus.out_avail); end
         end
         if (k == 4) begin
            checks++;
            if (bus.out_avail !== '1 || bus.out_sob !== 1'b1 || bus.out_data !== exp_data(cyc))
               begin failures++; $display("FAIL rstmid_first got=%h sob=%b data=%h want data=%h", bus.out_avail, bus.out_sob, bus.out_data, exp_data(cyc)); end
         end
         checks++;
         if (bus.error !== 2'b00)
            begin failures++; $display("FAIL rstmid_error k=%0d got=%b want=00", k, bus.error); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      s_rst         = 1'b1;
      bus.in_data   = '0;
      bus.in_avail  = '0;
      bus.in_sob    = 1'b0;
      bus.in_eob    = 1'b0;
      bus.in_sol    = 1'b0;
      bus.in_eol    = 1'b0;
      bus.in_sos    = 1'b0;
      bus.in_eos    = 1'b0;
      bus.in_pbs_id = '0;
      m_err         = 2'b00;
      m_inb         = 1'b0;
      rst_rec[0]    = 1'b1;
      err_rec[0]    = 2'b00;
      test_reset();
      test_corners();
      test_back_to_back();
      test_sob_error();
      test_partial_avail();
      test_reset_mid_batch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
